// File: rtl/instr_decode_q.sv
// RV32I/RV64I base-opcode decoder feeding a DEPTH-entry issue queue with an optional busy-register interlock.
// out_op codes: LOAD 0, MISC_MEM 1, OP_IMM 2, AUIPC 3, OP_IMM32 4, STORE 5, OP 6, LUI 7, OP32 8, BRANCH 9, JALR 10, JAL 11, SYSTEM 12, INVAL 15; out_fmt: R 0, I 1, S 2, B 3, U 4, J 5.
module instr_decode_q #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 2,
    parameter bit          HAZARD_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [9:0]        rs_idx,
    input  logic [2*XLEN-1:0] rs_val,
    input  logic [31:0]       busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [2:0]        out_fmt,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [2:0]        out_funct3,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [3:0] {
        OP_LOAD   = 4'd0,  OP_MISC_MEM = 4'd1,  OP_IMM  = 4'd2,  OP_AUIPC  = 4'd3,
        OP_IMM32  = 4'd4,  OP_STORE    = 4'd5,  OP_OP   = 4'd6,  OP_LUI    = 4'd7,
        OP_OP32   = 4'd8,  OP_BRANCH   = 4'd9,  OP_JALR = 4'd10, OP_JAL    = 4'd11,
        OP_SYSTEM = 4'd12, INSTR_INVAL = 4'd15
    } instr_op;

    typedef enum logic [2:0] {
        FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
    } instr_fmt;

    typedef struct packed {
        instr_op         op;
        instr_fmt        fmt;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
    } entry_t;

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    entry_t        dec;
    entry_t        head;
    entry_t        mem_q [DEPTH];
    logic [31:0]   imm32;
    logic          hazard;
    logic          accept;
    logic          pop;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   stall_q, stall_d;

    always_comb begin
        dec     = '0;
        dec.op  = INSTR_INVAL;
        dec.fmt = FMT_I;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:2])
                5'b00000: dec.op = OP_LOAD;
                5'b00011: dec.op = OP_MISC_MEM;
                5'b00100: dec.op = OP_IMM;
                5'b00101: begin dec.op = OP_AUIPC;  dec.fmt = FMT_U; end
                5'b00110: if (XLEN == 64) dec.op = OP_IMM32;
                5'b01000: begin dec.op = OP_STORE;  dec.fmt = FMT_S; end
                5'b01100: begin dec.op = OP_OP;     dec.fmt = FMT_R; end
                5'b01101: begin dec.op = OP_LUI;    dec.fmt = FMT_U; end
                5'b01110: if (XLEN == 64) begin dec.op = OP_OP32; dec.fmt = FMT_R; end
                5'b11000: begin dec.op = OP_BRANCH; dec.fmt = FMT_B; end
                5'b11001: dec.op = OP_JALR;
                5'b11011: begin dec.op = OP_JAL;    dec.fmt = FMT_J; end
                5'b11100: dec.op = OP_SYSTEM;
                default:  dec.op = INSTR_INVAL;
            endcase
        end

        case (dec.fmt)
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'b0};
            FMT_J:   imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        endcase

        // Unused register fields are forced to x0 so they never trip the interlock.
        dec.rs1     = (dec.fmt == FMT_U || dec.fmt == FMT_J) ? '0 : in_instr[19:15];
        dec.rs2     = (dec.fmt == FMT_R || dec.fmt == FMT_S || dec.fmt == FMT_B) ? in_instr[24:20] : '0;
        dec.rd      = (dec.fmt == FMT_S || dec.fmt == FMT_B) ? '0 : in_instr[11:7];
        dec.funct3  = in_instr[14:12];
        dec.imm     = XLEN'($signed(imm32));
        dec.pc      = in_pc;
        dec.rs1_val = rs_val[XLEN-1:0];
        dec.rs2_val = rs_val[2*XLEN-1:XLEN];
    end

    assign rs_idx   = {dec.rs2, dec.rs1};
    assign hazard   = HAZARD_CHECK && in_valid &&
                      ((dec.rs1 != '0 && busy[dec.rs1]) || (dec.rs2 != '0 && busy[dec.rs2]));
    assign in_ready = !flush && !hazard && (count_q < FULL || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign pop      = out_valid && out_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;
        if (in_valid && !in_ready && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (accept) tail_d = tail_q + 1'b1;
            if (pop)    head_d = head_q + 1'b1;
            case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[tail_q] <= dec;
    end

    assign head        = mem_q[head_q];
    assign out_op      = head.op;
    assign out_fmt     = head.fmt;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_funct3  = head.funct3;
    assign out_imm     = head.imm;
    assign out_pc      = head.pc;
    assign out_rs1_val = head.rs1_val;
    assign out_rs2_val = head.rs2_val;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_instr_decode_q.sv
// Randomised bench for instr_decode_q: a queue-based reference model checks every cycle, plus directed corner cases.
module tb_instr_decode_q;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    localparam logic [3:0] OP_LOAD = 4'd0, OP_MISC = 4'd1, OP_IMM = 4'd2, OP_AUIPC = 4'd3,
                           OP_IMM32 = 4'd4, OP_STORE = 4'd5, OP_OP = 4'd6, OP_LUI = 4'd7,
                           OP_OP32 = 4'd8, OP_BRANCH = 4'd9, OP_JALR = 4'd10, OP_JAL = 4'd11,
                           OP_SYSTEM = 4'd12, INSTR_INVAL = 4'd15;
    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
    localparam logic [63:0] B_V1 = {59'h123456789ABCDEF, 5'd5};
    localparam logic [63:0] B_V2 = {59'h0A5A5A5A5A5A5A5, 5'd6};

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]       in_instr, busy, stall_cnt;
    logic [XLEN-1:0]   in_pc;
    logic [9:0]        rs_idx;
    logic [2*XLEN-1:0] rs_val;
    logic [3:0]        out_op;
    logic [2:0]        out_fmt, out_funct3;
    logic [4:0]        out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0]   out_imm, out_pc, out_rs1_val, out_rs2_val;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_instr, b_busy, b_stall_cnt;
    logic [63:0] b_in_pc, b_out_imm, b_out_pc, b_out_rs1_val, b_out_rs2_val;
    logic [9:0]  b_rs_idx;
    logic [127:0] b_rs_val;
    logic [3:0]  b_out_op;
    logic [2:0]  b_out_fmt, b_out_funct3;
    logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;

    logic [XLEN-1:0] regs [32];
    logic [3:0]      op_tab [32];
    logic [2:0]      fmt_tab [32];
    logic [6:0]      opcs [13];

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  fmt;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [63:0] imm, pc, v1, v2;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] m_stall;
    int          n_checks, n_errors;

    always #5 clk = ~clk;

    assign rs_val   = {regs[rs_idx[9:5]], regs[rs_idx[4:0]]};
    assign b_rs_val = {59'h0A5A5A5A5A5A5A5, b_rs_idx[9:5], 59'h123456789ABCDEF, b_rs_idx[4:0]};

    instr_decode_q #(.XLEN(XLEN), .DEPTH(DEPTH), .HAZARD_CHECK(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs_idx(rs_idx), .rs_val(rs_val), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_fmt(out_fmt),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_imm(out_imm), .out_pc(out_pc), .out_rs1_val(out_rs1_val),
        .out_rs2_val(out_rs2_val), .stall_cnt(stall_cnt)
    );

    instr_decode_q #(.XLEN(64), .DEPTH(4), .HAZARD_CHECK(1'b0)) u_dut_nohaz (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(b_in_pc), .rs_idx(b_rs_idx), .rs_val(b_rs_val), .busy(b_busy),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_op(b_out_op), .out_fmt(b_out_fmt),
        .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_funct3(b_out_funct3),
        .out_imm(b_out_imm), .out_pc(b_out_pc), .out_rs1_val(b_out_rs1_val),
        .out_rs2_val(b_out_rs2_val), .stall_cnt(b_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t   e;
        longint imm;
        e = '{default: '0};
        e.op  = INSTR_INVAL;
        e.fmt = F_I;
        if (ins[1:0] == 2'b11) begin
            e.op  = op_tab[ins[6:2]];
            e.fmt = fmt_tab[ins[6:2]];
        end
        e.rs1 = (e.fmt inside {F_U, F_J})      ? 5'd0 : ins[19:15];
        e.rs2 = (e.fmt inside {F_R, F_S, F_B}) ? ins[24:20] : 5'd0;
        e.rd  = (e.fmt inside {F_S, F_B})      ? 5'd0 : ins[11:7];
        e.f3  = ins[14:12];
        case (e.fmt)
            F_S:     imm = $signed({ins[31:25], ins[11:7]});
            F_B:     imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
            F_U:     imm = $signed(ins[31:12]) * 4096;
            F_J:     imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
            default: imm = $signed(ins[31:20]);
        endcase
        e.imm = imm & 64'hFFFF_FFFF;
        return e;
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] im);
        return {im, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 12)];
        return w;
    endfunction

    task automatic check_head(input exp_t e);
        chk("op", out_op, e.op);
        chk("fmt", out_fmt, e.fmt);
        chk("rs1", out_rs1, e.rs1);
        chk("rs2", out_rs2, e.rs2);
        chk("rd", out_rd, e.rd);
        chk("funct3", out_funct3, e.f3);
        chk("imm", out_imm, e.imm);
        chk("pc", out_pc, e.pc);
        chk("rs1_val", out_rs1_val, e.v1);
        chk("rs2_val", out_rs2_val, e.v2);
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        exp_t nxt;
        bit   hz, rdy, acc, pp;
        #1;
        nxt = ref_decode(in_instr);
        hz  = in_valid && ((nxt.rs1 != 0 && busy[nxt.rs1]) || (nxt.rs2 != 0 && busy[nxt.rs2]));
        rdy = !flush && !hz && (mq.size() < DEPTH || out_ready);
        chk("in_ready", in_ready, rdy);
        chk("rs_idx", rs_idx, {nxt.rs2, nxt.rs1});
        chk("out_valid", out_valid, mq.size() != 0);
        chk("stall_cnt", stall_cnt, m_stall);
        if (mq.size() != 0) check_head(mq[0]);
        acc = in_valid && rdy;
        pp  = (mq.size() != 0) && out_ready && !flush;
        nxt.pc = in_pc;
        nxt.v1 = regs[nxt.rs1];
        nxt.v2 = regs[nxt.rs2];
        @(posedge clk);
        if (in_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (flush) mq.delete();
        else begin
            if (pp)  void'(mq.pop_front());
            if (acc) mq.push_back(nxt);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit fl, input logic [31:0] bsy);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; busy = bsy;
        step();
    endtask

    initial begin
        logic [31:0] va, vb;
        n_checks = 0; n_errors = 0; m_stall = 0;
        for (int i = 0; i < 32; i++) begin
            op_tab[i] = INSTR_INVAL; fmt_tab[i] = F_I; regs[i] = (i == 0) ? '0 : $urandom;
        end
        op_tab[5'h00] = OP_LOAD;   op_tab[5'h03] = OP_MISC;  op_tab[5'h04] = OP_IMM;
        op_tab[5'h05] = OP_AUIPC;  fmt_tab[5'h05] = F_U;
        op_tab[5'h08] = OP_STORE;  fmt_tab[5'h08] = F_S;
        op_tab[5'h0C] = OP_OP;     fmt_tab[5'h0C] = F_R;
        op_tab[5'h0D] = OP_LUI;    fmt_tab[5'h0D] = F_U;
        op_tab[5'h18] = OP_BRANCH; fmt_tab[5'h18] = F_B;
        op_tab[5'h19] = OP_JALR;
        op_tab[5'h1B] = OP_JAL;    fmt_tab[5'h1B] = F_J;
        op_tab[5'h1C] = OP_SYSTEM;
        opcs = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

        rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; busy = 0;
        b_flush = 0; b_in_valid = 0; b_in_instr = 0; b_in_pc = 0; b_out_ready = 1; b_busy = 0;
        @(negedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        in_valid = 1; in_instr = 32'hFFF10093;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_stall", stall_cnt, 0);
        in_valid = 0;
        @(negedge clk);
        rst = 0;

        // addi x1,x2,-1: one-cycle latency
        drive(1, 32'hFFF10093, 32'h100, 1, 0, 0);
        in_valid = 0; #1;
        chk("addi_valid", out_valid, 1);
        chk("addi_op", out_op, OP_IMM);
        chk("addi_rs1", out_rs1, 2);
        chk("addi_rs2", out_rs2, 0);
        chk("addi_rd", out_rd, 1);
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_pc", out_pc, 32'h100);
        step();

        // back-pressure: two accepted, third held
        drive(1, addi(1, 2, 11), 32'h200, 0, 0, 0);
        drive(1, addi(3, 4, 22), 32'h204, 0, 0, 0);
        repeat (3) drive(1, addi(5, 6, 33), 32'h208, 0, 0, 0);
        chk("bp_stall3", stall_cnt, 3);
        drive(1, addi(5, 6, 33), 32'h208, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 0, 0);

        // busy interlock on rs1, operand sampled at accept
        va = $urandom; vb = ~va;
        regs[5] = va;
        repeat (3) drive(1, 32'h006281B3, 32'h300, 1, 0, 32'h20);
        chk("haz_stall", stall_cnt, 6);
        regs[5] = vb;
        drive(1, 32'h006281B3, 32'h300, 1, 0, 32'h0);
        in_valid = 0; #1;
        chk("haz_rs1_val", out_rs1_val, vb);
        chk("haz_rd", out_rd, 3);
        chk("haz_op", out_op, OP_OP);
        step();
        drive(1, addi(1, 0, 5), 32'h304, 1, 0, 32'h1);
        drive(0, 0, 0, 1, 0, 0);

        // full queue streaming across pointer wrap
        drive(1, addi(1, 2, 1), 32'h400, 0, 0, 0);
        drive(1, addi(2, 3, 2), 32'h404, 0, 0, 0);
        for (int i = 0; i < 3 * DEPTH; i++) drive(1, addi(5'(i + 3), 5'(i + 4), 12'(i)), 32'h408 + 32'(4 * i), 1, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 0, 0);

        // flush with two queued
        drive(1, addi(1, 2, 3), 32'h500, 0, 0, 0);
        drive(1, addi(2, 3, 4), 32'h504, 0, 0, 0);
        drive(1, addi(3, 4, 5), 32'h508, 0, 1, 0);
        in_valid = 0; flush = 0; #1;
        chk("flush_empty", out_valid, 0);
        step();
        drive(1, addi(7, 8, 77), 32'h600, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);

        // invalid encodings
        drive(1, 32'h0000_0000, 32'h700, 1, 0, 0);
        in_valid = 0; #1;
        chk("inval_zero", out_op, INSTR_INVAL);
        step();
        drive(1, 32'h0000_007F, 32'h704, 1, 0, 0);
        in_valid = 0; #1;
        chk("inval_7f", out_op, INSTR_INVAL);
        step();

        // reset mid-stream
        drive(1, addi(1, 2, 6), 32'h800, 0, 0, 0);
        drive(1, addi(2, 3, 7), 32'h804, 0, 0, 0);
        drive(1, addi(3, 4, 8), 32'h808, 0, 0, 0);
        #2 rst = 1; #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        mq.delete(); m_stall = 0;
        @(negedge clk);
        in_valid = 0; rst = 0;
        step();
        drive(1, addi(9, 10, 9), 32'h900, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);

        // 64-bit instance with interlock disabled
        b_in_valid = 1; b_in_instr = 32'h006281B3; b_busy = 32'h20; b_in_pc = 64'h8000_0000_0000_0010;
        #1 chk("b_nohaz_ready", b_in_ready, 1);
        @(negedge clk);
        b_in_instr = 32'hFFF1009B; b_in_pc = 64'h8000_0000_0000_0014;
        #1;
        chk("b_add_valid", b_out_valid, 1);
        chk("b_add_op", b_out_op, OP_OP);
        chk("b_add_v1", b_out_rs1_val, B_V1);
        chk("b_add_v2", b_out_rs2_val, B_V2);
        chk("b_add_pc", b_out_pc, 64'h8000_0000_0000_0010);
        @(negedge clk);
        b_in_instr = 32'h800000B7;
        #1;
        chk("b_addiw_op", b_out_op, OP_IMM32);
        chk("b_addiw_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        b_in_valid = 0;
        #1;
        chk("b_lui_op", b_out_op, OP_LUI);
        chk("b_lui_imm", b_out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("b_lui_rs1", b_out_rs1, 0);
        @(negedge clk); #1;
        chk("b_drained", b_out_valid, 0);
        @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) regs[$urandom_range(1, 31)] = $urandom;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            busy      = $urandom & $urandom & $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_q.md
INSTR_DECODE_Q -- requirements
Module: instr_decode_q

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the register, immediate and pc width (32 or 64).
REQ-002 The block SHALL take parameter DEPTH, default 2, as the number of decoded-instruction queue entries (power of two, 2..8).
REQ-003 The block SHALL take parameter HAZARD_CHECK, default 1; 1 enables the busy-register interlock, 0 disables it.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  discard queue contents and refuse input this cycle.
REQ-007 in_valid / in_ready  input / output  1 / 1  fetch handshake.
REQ-008 in_instr / in_pc  input / input  32 / XLEN  raw instruction and its pc.
REQ-009 rs_idx  output  2x5  regfile read indices for rs1, rs2 (combinational from in_instr).
REQ-010 rs_val  input  2xXLEN  regfile read data, same cycle as rs_idx.
REQ-011 busy  input  32  scoreboard mask; bit n set = register n has a pending write.
REQ-012 out_valid / out_ready  output / input  1 / 1  issue handshake.
REQ-013 out_op, out_fmt  output  instr_op, instr_fmt  decoded opcode class and format.
REQ-014 out_rs1, out_rs2, out_rd  output  5 each  register indices, 0 when unused by format.
REQ-015 out_funct3 / out_imm / out_pc  output  3 / XLEN / XLEN  funct3, sign-extended immediate, pc.
REQ-016 out_rs1_val, out_rs2_val  output  XLEN each  operand values captured at accept.
REQ-017 stall_cnt  output  32  count of cycles with in_valid=1 and in_ready=0.

Function
REQ-018 Decode SHALL follow RV32I/RV64I base opcode map: in_instr[1:0]!=2'b11 or unknown opcode[6:2] -> INSTR_INVAL; I/S/B/U/J immediates sign-extended from bit 31 to XLEN; R-type treated as I for imm.
REQ-019 rs1 is used unless fmt U/J; rs2 only for R/S/B; rd unused for S/B; unused fields SHALL read 0, and x0 SHALL never count as busy.
REQ-020 hazard = HAZARD_CHECK & in_valid & ((rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2])).
REQ-021 in_ready = !flush & !hazard & (count<DEPTH | out_ready); accept = in_valid & in_ready.
REQ-022 On accept the fully decoded entry, including rs_val, SHALL be written at the tail pointer in the same edge; latency in->out is exactly 1 cycle when queue is empty.
REQ-023 out_valid = (count!=0); outputs SHALL present the head entry; pop = out_valid & out_ready & !flush.
REQ-024 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL update by +accept-pop; simultaneous accept and pop when full SHALL keep count=DEPTH.
REQ-025 Head entry SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL set count, head, tail to 0 on the next edge and override any same-cycle accept or pop.
REQ-027 INSTR_INVAL entries SHALL be queued and issued like any other (trap handled downstream).
REQ-028 stall_cnt SHALL increment by 1 per stall cycle, saturating at 2^32-1; flush does not clear it.

Reset
REQ-029 While rst=1: count, head, tail = 0; out_valid = 0; stall_cnt = 0; in_ready follows REQ-021 with count=0.
REQ-030 Reset asserted mid-transfer SHALL drop all queued entries; no entry accepted before reset appears after it.
REQ-031 Queue storage need not be reset; out_* data fields are don't-care while out_valid=0.

Verification
REQ-032 Single addi x1,x2,-1 (0xFFF10093) pc=0x100, out_ready=1 -> next cycle out_valid=1, op OP_IMM, rs1=2, rs2=0, rd=1, imm=all ones, pc=0x100.
REQ-033 out_ready=0, DEPTH=2, three back-to-back valid instrs -> first two accepted, in_ready=0 on third, stall_cnt increments each held cycle, order preserved on release.
REQ-034 busy[5]=1, in_instr add x3,x5,x6 -> in_ready=0 until busy[5] clears, then accepted with rs1_val sampled that cycle; same test with HAZARD_CHECK=0 -> accepted immediately.
REQ-035 Queue full plus out_ready=1 plus in_valid=1 -> accept and pop same edge, count stays DEPTH, pointers wrap correctly over 3*DEPTH transfers.
REQ-036 flush with 2 queued and in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, dropped instrs never appear.
REQ-037 in_instr=0x00000000 and opcode 7'b1111111 -> out_op=INSTR_INVAL; rst pulse mid-stream -> out_valid=0 immediately, stall_cnt=0.
